dense_neuron_mac: RTL and testbench
===================================

Name: dense_neuron_mac

Overview:
Streaming fixed-point neuron that computes one pre-activation value, y = bias + sum(x[i]*w[i]) for i = 0..NUM_IN-1, in signed Q(N,Q) format. It sits directly upstream of the tanh activation stage and feeds it one saturated N-bit result per neuron evaluation. Inputs arrive as one (x, w) pair per accepted beat on a valid/ready stream. The output is held under a valid/ready handshake.

Parameters:
- N, 32, total word width of x, w, bias and result (two's complement).
- Q, 16, fractional bits. Same format on every input and output.
- NUM_IN, 16, number of (x, w) pairs per evaluation. Legal range 1..1024.
- GUARD, 10, accumulator guard bits. Must be at least ceil(log2(NUM_IN)).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous reset, active-high.
- start, input, 1, begin an evaluation. Sampled only in IDLE.
- bias, input, N, neuron bias in Q format. Latched when start is taken.
- in_valid, input, 1, x/w pair valid.
- in_ready, output, 1, block accepts a pair this cycle.
- x, input, N, activation input sample.
- w, input, N, weight sample.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream (tanh stage) accepts the result.
- out_data, output, N, saturated pre-activation in Q format.
- sat, output, 1, out_data was clipped. Valid while out_valid is high.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset is synchronous and active-high on rst; single clock clk. While rst is high: state=IDLE, out_valid=0, out_data=0, sat=0, in_ready=0, busy=0, accumulator=0, beat counter=0, product-valid register=0.
- rst asserted mid-evaluation aborts it. Partial sums are discarded and no out_valid is produced.
- States:
  - IDLE: in_ready=0. If start=1, latch bias, clear the accumulator, clear the counter, and go to ACC. start is ignored in every other state.
  - ACC: in_ready=1. A beat is accepted when in_valid&&in_ready. Each accepted beat increments the counter. When the beat with counter==NUM_IN-1 is accepted, go to DRAIN. The block never pre-accepts beats of the next evaluation.
  - DRAIN: in_ready=0. Wait one cycle for the last product to be accumulated, then go to FIN.
  - FIN: compute the result, register out_data/sat, set out_valid=1, go to OUT.
  - OUT: hold out_data, sat and out_valid stable until out_ready=1. On the cycle out_valid&&out_ready, clear out_valid and return to IDLE. start in that same cycle is ignored; the next start is accepted one cycle later.
- Pipeline:
  - The product register p <= x*w is full 2N-bit signed and is loaded on each accepted beat.
  - The accumulator acc (2N+GUARD bits, signed) adds p one cycle later when the product-valid flag is set.
  - Accepted beats may be non-consecutive; gaps in in_valid only stall the pipeline.
- Latency: last beat accepted at cycle t, then out_valid=1 at cycle t+3 (p at t+1, acc at t+2, FIN register at t+3). Minimum evaluation time is NUM_IN+4 cycles including the start cycle.
- Arithmetic:
  - Signed multiply; no sign-magnitude handling.
  - sum = acc + (sign-extended bias << Q).
  - Scale by an arithmetic shift right by Q (floor, default).
  - Saturate to N-bit signed: above 2^(N-1)-1 gives 0x7FF..F, below -2^(N-1) gives 0x800..0, and sat=1 in either case. Otherwise sat=0.
- No internal overflow is possible in acc when GUARD >= ceil(log2(NUM_IN)).
- x and w are don't-care when not accepted. X on those inputs must not propagate into acc.

Optional Feature:
Macro DENSE_MAC_ROUND_EN.
- Defined: add 2^(Q-1) to sum before the shift right by Q, giving round-half-up.
- Undefined: plain floor truncation.
- Saturation is applied after rounding in both cases.

Test Plan:
1. Basic result: NUM_IN=4, bias=0x00004000 (0.25), x=0x00010000 (1.0) and w=0x00008000 (0.5) on all 4 beats back-to-back -> out_data=0x00024000 (2.25), sat=0, out_valid 3 cycles after the last beat.
2. Positive saturation: NUM_IN=4, x=w=0x007F0000 (127.0), bias=0 -> out_data=0x7FFFFFFF, sat=1. Repeat with w=0xFF810000 (-127.0) -> out_data=0x80000000, sat=1.
3. Backpressure and input gaps: case 1 with in_valid toggling 1,0,0,1,0,1,1 and out_ready held low for 5 cycles -> same 0x00024000; out_data stable while waiting; in_ready=0 throughout DRAIN/FIN/OUT; start pulses during OUT are ignored.
4. Rounding: NUM_IN=1, bias=0, x=0x00000001, w=0x00008000 -> out_data=0x00000000 without the macro, 0x00000001 with DENSE_MAC_ROUND_EN. A negative case, x=0xFFFFFFFF with the same w, gives 0xFFFFFFFF without the macro and 0x00000000 with it.
5. Reset mid-operation: assert rst for 1 cycle after 2 of 4 beats -> no out_valid. busy=0 and in_ready=0 the next cycle. A fresh start reproduces case 1 exactly.
6. Back-to-back evaluations: two consecutive evaluations with different bias values (0.25, then -1.0=0xFFFF0000) -> results 0x00024000 and then 0x00010000, no carry-over between evaluations.

Source files
------------

// File: rtl/dense_neuron_mac_if.sv
// Stream bundle for dense_neuron_mac: start/bias control, x/w input beats,
// and the held result handshake toward the activation stage.
interface dense_neuron_mac_if #(
   parameter int N = 32
);
   logic         start;
   logic [N-1:0] bias;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] x;
   logic [N-1:0] w;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         sat;
   logic         busy;

   modport master (
      output start, bias, in_valid, x, w, out_ready,
      input  in_ready, out_valid, out_data, sat, busy
   );

   modport slave (
      input  start, bias, in_valid, x, w, out_ready,
      output in_ready, out_valid, out_data, sat, busy
   );
endinterface

// File: rtl/dense_neuron_mac.sv
// Streaming neuron MAC: y = bias + sum(x[i]*w[i]) in signed Q(N,Q), saturated to N bits.
// Optional DENSE_MAC_ROUND_EN selects round-half-up instead of floor before the Q shift.
module dense_neuron_mac #(
   parameter int N      = 32,
   parameter int Q      = 16,
   parameter int NUM_IN = 16,
   parameter int GUARD  = 10
) (
   input logic               clk,
   input logic               rst,
   dense_neuron_mac_if.slave bus
);
   localparam int AW = 2 * N + GUARD;
   localparam int SW = AW + 2;
   localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW - N + 1){1'b0}}, {(N - 1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {
      IDLE,
      ACC,
      DRAIN,
      FIN,
      OUT
   } state_t;

   state_t                 r_state;
   logic [N-1:0]           r_bias;
   logic [CW-1:0]          r_cnt;
   logic signed [2*N-1:0]  r_p;
   logic                   r_pv;
   logic signed [AW-1:0]   r_acc;
   logic [N-1:0]           r_out_data;
   logic                   r_sat;
   logic                   r_out_valid;
   logic                   r_in_ready;
   logic                   r_busy;

   logic                   w_accept;
   logic signed [2*N-1:0]  w_prod;
   logic signed [SW-1:0]   w_bias_ext;
   logic signed [SW-1:0]   w_rnd;
   logic signed [SW-1:0]   w_sum;
   logic signed [SW-1:0]   w_shr;
   logic                   w_hi;
   logic                   w_lo;
   logic [N-1:0]           w_res;

   assign w_accept = bus.in_valid && r_in_ready;
   assign w_prod   = (2 * N)'($signed(bus.x)) * (2 * N)'($signed(bus.w));

   always_comb begin
      w_bias_ext = SW'($signed(r_bias)) <<< Q;
`ifdef DENSE_MAC_ROUND_EN
      w_rnd = SW'(1) <<< (Q - 1);
`else
      w_rnd = '0;
`endif
      w_sum = SW'(r_acc) + w_bias_ext + w_rnd;
      w_shr = w_sum >>> Q;
      w_hi  = w_shr > SAT_MAX;
      w_lo  = w_shr < SAT_MIN;
      w_res = w_shr[N-1:0];
      if (w_hi) begin
         w_res = {1'b0, {(N - 1){1'b1}}};
      end else if (w_lo) begin
         w_res = {1'b1, {(N - 1){1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_bias      <= '0;
         r_cnt       <= '0;
         r_p         <= '0;
         r_pv        <= 1'b0;
         r_acc       <= '0;
         r_out_data  <= '0;
         r_sat       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // Product stage loads only on accepted beats so idle x/w never reach acc.
         r_pv <= w_accept;
         if (w_accept) begin
            r_p <= w_prod;
         end
         if (r_pv) begin
            r_acc <= r_acc + AW'(r_p);
         end

         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_bias     <= bus.bias;
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ACC;
               end
            end
            ACC: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == CW'(NUM_IN - 1)) begin
                     r_in_ready <= 1'b0;
                     r_state    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               r_state <= FIN;
            end
            FIN: begin
               r_out_data  <= w_res;
               r_sat       <= w_hi | w_lo;
               r_out_valid <= 1'b1;
               r_state     <= OUT;
            end
            OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.sat       = r_sat;
   assign bus.busy      = r_busy;
endmodule

// File: tb/tb_dense_neuron_mac.sv
// Scoreboard bench for dense_neuron_mac: directed cases plus randomized evaluations
// checked against a wide-integer arithmetic model of the neuron.
module tb_dense_neuron_mac;
   localparam int N      = 32;
   localparam int Q      = 16;
   localparam int NUM_IN = 4;
   localparam int GUARD  = 10;

   typedef logic [N-1:0] vec_t [NUM_IN];
   typedef struct {
      logic [N-1:0] d;
      logic         s;
      int           vc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   hold_n = 0;
   bit   rand_ready = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dense_neuron_mac_if #(.N(N)) bus ();

   dense_neuron_mac #(
      .N(N),
      .Q(Q),
      .NUM_IN(NUM_IN),
      .GUARD(GUARD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [N-1:0] b, input vec_t xs, input vec_t ws,
                                  input int vc);
      logic signed [127:0] s, r, mx, mn;
      exp_t e;
      s = 128'($signed(b)) * (128'sd1 <<< Q);
      for (int i = 0; i < NUM_IN; i++)
         s = s + 128'($signed(xs[i])) * 128'($signed(ws[i]));
`ifdef DENSE_MAC_ROUND_EN
      s = s + (128'sd1 <<< (Q - 1));
`endif
      r  = s >>> Q;
      mx = (128'sd1 <<< (N - 1)) - 128'sd1;
      mn = -(128'sd1 <<< (N - 1));
      if (r > mx) begin
         e.d = mx[N-1:0];
         e.s = 1'b1;
      end else if (r < mn) begin
         e.d = mn[N-1:0];
         e.s = 1'b1;
      end else begin
         e.d = r[N-1:0];
         e.s = 1'b0;
      end
      e.vc = vc;
      return e;
   endfunction

   // Output-ready driver: optional forced hold while a result waits, else random or high.
   always @(posedge clk) begin
      #1;
      if (bus.out_valid && hold_n > 0) begin
         bus.out_ready = 1'b0;
         hold_n--;
      end else begin
         bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on each output handshake and checks hold stability.
   logic         prev_v = 1'b0;
   logic         prev_wait = 1'b0;
   logic [N-1:0] pd;
   logic         ps;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_v    = 1'b0;
         prev_wait = 1'b0;
      end else begin
         if (bus.out_valid) chk("in_ready_low_while_out_valid", 64'(bus.in_ready), 64'd0);
         if (prev_wait) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_data", 64'(bus.out_data), 64'(pd));
            chk("hold_sat", 64'(bus.sat), 64'(ps));
         end
         if (bus.out_valid && !prev_v) begin
            if (q.size() == 0) fail_now("unexpected_out_valid");
            else chk("latency_cycle", 64'(cyc), 64'(q[0].vc));
         end
         if (bus.out_valid && bus.out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("out_data", 64'(bus.out_data), 64'(e.d));
            chk("sat", 64'(bus.sat), 64'(e.s));
         end
         prev_v    = bus.out_valid;
         prev_wait = bus.out_valid && !bus.out_ready;
         pd        = bus.out_data;
         ps        = bus.sat;
      end
   end

   task automatic do_start(input logic [N-1:0] b);
      int n = 0;
      while (bus.busy && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) fail_now("timeout_wait_idle");
      bus.bias  = b;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic run_eval(input logic [N-1:0] b, input vec_t xs, input vec_t ws,
                           input int gapmode);
      bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      int i = 0;
      int g = 0;
      int t = 0;
      int tn;
      bit v, acc;
      do_start(b);
      while (i < NUM_IN && g < 500) begin
         if (gapmode == 0) v = 1'b1;
         else if (gapmode == 1) v = 1'($urandom_range(0, 1));
         else v = pat[g % 7];
         bus.in_valid = v;
         bus.x = v ? xs[i] : N'($urandom);
         bus.w = v ? ws[i] : N'($urandom);
         acc = v && bus.in_ready;
         tn  = cyc;
         step();
         if (acc) begin
            if (i == NUM_IN - 1) t = tn;
            i++;
         end
         g++;
      end
      bus.in_valid = 1'b0;
      if (g >= 500) fail_now("timeout_beats");
      q.push_back(model(b, xs, ws, t + 3));
      chk("in_ready_drain", 64'(bus.in_ready), 64'd0);
      step();
      chk("in_ready_fin", 64'(bus.in_ready), 64'd0);
   endtask

   vec_t xa, wa;
   initial begin
      int n;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.bias = '0;
      bus.in_valid = 1'b0;
      bus.x = '0;
      bus.w = '0;
      bus.out_ready = 1'b1;
      repeat (3) step();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_sat", 64'(bus.sat), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      rst = 1'b0;
      step();

      // Basic 2.25 result
      xa = '{default: 32'h0001_0000};
      wa = '{default: 32'h0000_8000};
      run_eval(32'h0000_4000, xa, wa, 0);

      // Saturation both directions
      xa = '{default: 32'h007F_0000};
      wa = '{default: 32'h007F_0000};
      run_eval(32'h0, xa, wa, 0);
      wa = '{default: 32'hFF81_0000};
      run_eval(32'h0, xa, wa, 0);

      // Gaps, held backpressure, start pulses ignored during OUT
      xa = '{default: 32'h0001_0000};
      wa = '{default: 32'h0000_8000};
      hold_n = 5;
      run_eval(32'h0000_4000, xa, wa, 2);
      n = 0;
      while (!bus.out_valid && n < 10) begin step(); n++; end
      while (bus.out_valid && n < 60) begin
         bus.start = 1'b1;
         bus.bias  = N'($urandom);
         step();
         n++;
      end
      bus.start = 1'b0;
      if (n >= 60) fail_now("timeout_out_wait");
      chk("idle_after_out_busy", 64'(bus.busy), 64'd0);
      step();
      chk("start_ignored_busy", 64'(bus.busy), 64'd0);
      chk("start_ignored_in_ready", 64'(bus.in_ready), 64'd0);

      // Rounding, positive and negative half LSB
      xa = '{32'h0000_0001, 32'h0, 32'h0, 32'h0};
      wa = '{default: 32'h0000_8000};
      run_eval(32'h0, xa, wa, 0);
      xa = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
      run_eval(32'h0, xa, wa, 0);

      // Reset after two beats aborts the evaluation
      do_start(32'h1234_0000);
      bus.in_valid = 1'b1;
      bus.x = 32'h0100_0000;
      bus.w = 32'h0100_0000;
      repeat (2) step();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 64'(bus.busy), 64'd0);
      chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      repeat (8) step();
      xa = '{default: 32'h0001_0000};
      wa = '{default: 32'h0000_8000};
      run_eval(32'h0000_4000, xa, wa, 0);

      // Back-to-back with different bias
      run_eval(32'h0000_4000, xa, wa, 0);
      run_eval(32'hFFFF_0000, xa, wa, 0);

      // Randomized evaluations with random gaps and random out_ready
      rand_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
         for (int j = 0; j < NUM_IN; j++) begin
            if (k % 2 == 0) begin
               xa[j] = N'($signed(32'($urandom_range(0, 32'h003F_FFFF)) - 32'h0020_0000));
               wa[j] = N'($signed(32'($urandom_range(0, 32'h003F_FFFF)) - 32'h0020_0000));
            end else begin
               xa[j] = N'($urandom);
               wa[j] = N'($urandom);
            end
         end
         run_eval(N'($urandom), xa, wa, 1);
      end

      n = 0;
      while (q.size() != 0 && n < 300) begin step(); n++; end
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
